// File: rtl/alu_pkg.sv
// Shared opcode constants for the datapath ALU.
package alu_pkg;

  localparam int ALU_WIDTH = 32;

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_MUL = 3'b011;
  localparam logic [2:0] OP_DIV = 3'b100;
  localparam logic [2:0] OP_AND = 3'b101;
  localparam logic [2:0] OP_OR  = 3'b110;

endpackage

// File: rtl/alu_div.sv
// Combinational signed truncating divider.
// Flags divide-by-zero and MIN/-1 on div_err.
module alu_div #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem,
  output logic             div_err
);

  logic [WIDTH-1:0] ua;
  logic [WIDTH-1:0] ub;
  logic [WIDTH-1:0] ub_safe;
  logic [WIDTH-1:0] qm;
  logic [WIDTH-1:0] rm;
  logic             b_zero;
  logic             min_ovf;

  assign ua      = a[WIDTH-1] ? (~a + 1'b1) : a;
  assign ub      = b[WIDTH-1] ? (~b + 1'b1) : b;
  assign b_zero  = (b == '0);
  assign ub_safe = b_zero ? {{(WIDTH-1){1'b0}}, 1'b1} : ub;

  // Magnitude divide; MIN magnitude is representable unsigned.
  assign qm = ua / ub_safe;
  assign rm = ua % ub_safe;

  assign quot = (a[WIDTH-1] ^ b[WIDTH-1]) ? (~qm + 1'b1) : qm;
  assign rem  = a[WIDTH-1] ? (~rm + 1'b1) : rm;

  assign min_ovf = (a == {1'b1, {(WIDTH-1){1'b0}}})
                 && (b == '1);
  assign div_err = b_zero | min_ovf;

endmodule

// File: rtl/alu.sv
// Integer ALU: add/sub/mul/div/and/or with
// registered 2*WIDTH result, zero and overflow flags.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [2:0]         sel,
  output logic [2*WIDTH-1:0] result,
  output logic               z_f,
  output logic               o_f
);

  logic [WIDTH:0]            sum;
  logic [WIDTH:0]            diff;
  logic signed [2*WIDTH-1:0] prod;
  logic [WIDTH:0]            prod_hi;
  logic [WIDTH-1:0]          quot;
  logic [WIDTH-1:0]          rem;
  logic                      div_err;
  logic [2*WIDTH-1:0]        nxt_res;
  logic                      nxt_of;

  assign sum  = {a[WIDTH-1], a} + {b[WIDTH-1], b};
  assign diff = {a[WIDTH-1], a} - {b[WIDTH-1], b};
  assign prod = $signed(a) * $signed(b);

  // Product fits signed WIDTH only if top WIDTH+1 bits agree.
  assign prod_hi = prod[2*WIDTH-1:WIDTH-1];

  alu_div #(
    .WIDTH(WIDTH)
  ) u_div (
    .a      (a),
    .b      (b),
    .quot   (quot),
    .rem    (rem),
    .div_err(div_err)
  );

  always_comb begin
    nxt_res = '0;
    nxt_of  = 1'b0;
    unique case (sel)
      OP_ADD: begin
        nxt_res = {{(WIDTH-1){sum[WIDTH]}}, sum};
        nxt_of  = sum[WIDTH] ^ sum[WIDTH-1];
      end
      OP_SUB: begin
        nxt_res = {{(WIDTH-1){diff[WIDTH]}}, diff};
        nxt_of  = diff[WIDTH] ^ diff[WIDTH-1];
      end
      OP_MUL: begin
        nxt_res = prod;
        nxt_of  = ~((&prod_hi) | ~(|prod_hi));
      end
      OP_DIV: begin
        nxt_res = (b == '0) ? '0 : {rem, quot};
        nxt_of  = div_err;
      end
      OP_AND: nxt_res = {{WIDTH{1'b0}}, a & b};
      OP_OR:  nxt_res = {{WIDTH{1'b0}}, a | b};
      default: begin
        nxt_res = '0;
        nxt_of  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result <= '0;
      z_f    <= 1'b1;
      o_f    <= 1'b0;
    end else begin
      result <= nxt_res;
      z_f    <= (nxt_res == '0);
      o_f    <= nxt_of;
    end
  end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed cases plus
// random ops against a longint reference model.
module tb_alu;

  logic        clk;
  logic        rst;
  logic [31:0] a;
  logic [31:0] b;
  logic [2:0]  sel;
  logic [63:0] result;
  logic        z_f;
  logic        o_f;

  int chk_cnt;
  int pass_cnt;

  alu #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .a     (a),
    .b     (b),
    .sel   (sel),
    .result(result),
    .z_f   (z_f),
    .o_f   (o_f)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic void model(input  logic [2:0]  s,
                                input  logic [31:0] x,
                                input  logic [31:0] y,
                                output logic [63:0] r,
                                output logic        o);
    longint sa;
    longint sb;
    longint t;
    longint q;
    longint m;
    longint maxv;
    longint minv;
    sa   = longint'($signed(x));
    sb   = longint'($signed(y));
    maxv = 64'sd2147483647;
    minv = -64'sd2147483648;
    r = 64'd0;
    o = 1'b0;
    case (s)
      3'd1: begin
        t = sa + sb;
        r = t;
        o = (t > maxv) || (t < minv);
      end
      3'd2: begin
        t = sa - sb;
        r = t;
        o = (t > maxv) || (t < minv);
      end
      3'd3: begin
        t = sa * sb;
        r = t;
        o = (t > maxv) || (t < minv);
      end
      3'd4: begin
        if (sb == 0) begin
          r = 64'd0;
          o = 1'b1;
        end else begin
          q = sa / sb;
          m = sa % sb;
          r = {m[31:0], q[31:0]};
          o = (q > maxv);
        end
      end
      3'd5: r = {32'd0, x & y};
      3'd6: r = {32'd0, x | y};
      default: begin
        r = 64'd0;
        o = 1'b0;
      end
    endcase
  endfunction

  task automatic run(input string tag,
                     input logic [2:0]  s,
                     input logic [31:0] x,
                     input logic [31:0] y);
    logic [63:0] er;
    logic        eo;
    @(negedge clk);
    sel = s;
    a   = x;
    b   = y;
    model(s, x, y, er, eo);
    @(posedge clk);
    #1;
    chk({tag, ".res"}, result, er);
    chk({tag, ".z"}, {63'd0, z_f}, {63'd0, er == 64'd0});
    chk({tag, ".o"}, {63'd0, o_f}, {63'd0, eo});
  endtask

  task automatic run_lit(input string tag,
                         input logic [2:0]  s,
                         input logic [31:0] x,
                         input logic [31:0] y,
                         input logic [63:0] er,
                         input logic        ez,
                         input logic        eo);
    @(negedge clk);
    sel = s;
    a   = x;
    b   = y;
    @(posedge clk);
    #1;
    chk({tag, ".res"}, result, er);
    chk({tag, ".z"}, {63'd0, z_f}, {63'd0, ez});
    chk({tag, ".o"}, {63'd0, o_f}, {63'd0, eo});
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] v;
    case ($urandom_range(0, 7))
      0: v = 32'h8000_0000;
      1: v = 32'hFFFF_FFFF;
      2: v = 32'd0;
      3: v = 32'h7FFF_FFFF;
      4: v = $urandom_range(0, 20);
      5: v = -$urandom_range(1, 20);
      default: v = $urandom;
    endcase
    return v;
  endfunction

  initial begin
    chk_cnt  = 0;
    pass_cnt = 0;
    rst = 1'b1;
    sel = 3'd1;
    a   = 32'd6;
    b   = 32'd3;
    @(posedge clk);
    #1;
    chk("rst.res", result, 64'd0);
    chk("rst.z", {63'd0, z_f}, 64'd1);
    chk("rst.o", {63'd0, o_f}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    run_lit("add1", 3'd1, 32'd6, 32'd3, 64'd9, 1'b0, 1'b0);
    run_lit("add2", 3'd1, 32'd12, -32'd12, 64'd0, 1'b1, 1'b0);
    run_lit("add3", 3'd1, 32'h7000_0000, 32'h7000_0000,
            64'h0000_0000_E000_0000, 1'b0, 1'b1);
    run_lit("sub1", 3'd2, 32'd6, 32'd6, 64'd0, 1'b1, 1'b0);
    run_lit("sub2", 3'd2, 32'd12, -32'd12, 64'd24, 1'b0, 1'b0);
    run_lit("sub3", 3'd2, 32'h7000_0000, 32'h7000_0000,
            64'd0, 1'b1, 1'b0);
    run_lit("mul1", 3'd3, 32'd5, 32'd5, 64'd25, 1'b0, 1'b0);
    run_lit("mul2", 3'd3, 32'd4, 32'd0, 64'd0, 1'b1, 1'b0);
    run_lit("mul3", 3'd3, -32'd12, 32'd4,
            64'hFFFF_FFFF_FFFF_FFD0, 1'b0, 1'b0);
    run_lit("mul4", 3'd3, 32'h7000_0000, 32'd2,
            64'h0000_0000_E000_0000, 1'b0, 1'b1);
    run_lit("div1", 3'd4, 32'd5, 32'd5, 64'd1, 1'b0, 1'b0);
    run_lit("div2", 3'd4, 32'd4, 32'd0, 64'd0, 1'b1, 1'b1);
    run_lit("div3", 3'd4, -32'd12, 32'd4,
            64'h0000_0000_FFFF_FFFD, 1'b0, 1'b0);
    run_lit("div4", 3'd4, 32'h7000_0000, 32'd2,
            64'h0000_0000_3800_0000, 1'b0, 1'b0);
    run_lit("div5", 3'd4, 32'd7, -32'd2,
            64'h0000_0001_FFFF_FFFD, 1'b0, 1'b0);
    run_lit("div6", 3'd4, -32'd7, 32'd2,
            64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 1'b0);
    run_lit("divmin", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF,
            64'h0000_0000_8000_0000, 1'b0, 1'b1);
    run_lit("and1", 3'd5, 32'hFFFF_FFFF, 32'hAAAA_AAAA,
            64'h0000_0000_AAAA_AAAA, 1'b0, 1'b0);
    run_lit("and2", 3'd5, 32'hFFFF_FFFF, 32'd0, 64'd0, 1'b1, 1'b0);
    run_lit("or1", 3'd6, 32'h5555_5555, 32'hAAAA_AAAA,
            64'h0000_0000_FFFF_FFFF, 1'b0, 1'b0);
    run_lit("or2", 3'd6, 32'd0, 32'd0, 64'd0, 1'b1, 1'b0);
    run_lit("nop", 3'd0, 32'd9, 32'd9, 64'd0, 1'b1, 1'b0);
    run_lit("rsv", 3'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
            64'd0, 1'b1, 1'b0);

    run_lit("pre", 3'd3, 32'h7000_0000, 32'd4,
            64'h0000_0001_C000_0000, 1'b0, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    sel = 3'd3;
    a   = 32'h7000_0000;
    b   = 32'd4;
    @(posedge clk);
    #1;
    chk("midrst.res", result, 64'd0);
    chk("midrst.z", {63'd0, z_f}, 64'd1);
    chk("midrst.o", {63'd0, o_f}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 400; i++) begin
      run("rnd", 3'($urandom_range(0, 7)), pick(), pick());
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
